csr_arb: RTL and testbench
==========================

CSR_ARB -- requirements
Module: csr_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, the CSR byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the CSR data width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req0_i  input  1  requester 0 (SPI command path) access request; held high until done.
REQ-006 req0_we_i  input  1  requester 0 write (1) or read (0).
REQ-007 req0_lock_i  input  1  requester 0 keeps ownership across back-to-back accesses.
REQ-008 req0_addr_i  input  ADDR_WIDTH  requester 0 CSR address.
REQ-009 req0_wdata_i  input  DATA_WIDTH  requester 0 write data.
REQ-010 req0_done_o  output  1  one-cycle completion pulse to requester 0.
REQ-011 req0_rdata_o  output  DATA_WIDTH  requester 0 read data, valid while req0_done_o is high on a read.
REQ-012 req1_*  same set as REQ-005..REQ-011  requester 1 (NKMD core debug port).
REQ-013 csr_addr_o  output  ADDR_WIDTH  address to the csr block.
REQ-014 csr_ack_o  output  1  one-cycle write strobe to the csr block.
REQ-015 csr_wdata_o  output  DATA_WIDTH  write data to the csr block.
REQ-016 csr_rdata_i  input  DATA_WIDTH  csr block read data, valid one cycle after csr_addr_o is stable.

Function
REQ-017 SHALL implement the states IDLE, ISSUE and READ.
REQ-018 In IDLE, if any req is high, SHALL select a winner, latch its we, addr and wdata into internal registers, and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-019 In ISSUE, SHALL drive csr_addr_o and csr_wdata_o from the latched values.
REQ-020 In ISSUE on a write, SHALL pulse csr_ack_o and the winner's done_o for exactly one cycle, then return to IDLE.
REQ-021 In ISSUE on a read, SHALL keep csr_ack_o low and go to READ.
REQ-022 In READ, SHALL copy csr_rdata_i to the winner's rdata_o, pulse the winner's done_o for one cycle, and return to IDLE.
REQ-023 Timing from IDLE with req high in cycle 0: write done in cycle 2; read done in cycle 3.
REQ-024 csr_addr_o SHALL hold the latched address from ISSUE through READ; csr_ack_o SHALL never be high outside ISSUE.
REQ-025 rdata_o SHALL hold its last value until the next read completion for that requester.
REQ-026 Lock: if the owner's lock_i is high in its done cycle and its req is high in the next IDLE, the owner SHALL be re-granted regardless of the other request.
REQ-027 Simultaneous requests without lock SHALL be resolved by the arbitration policy in REQ-031.
REQ-028 A req dropped before done SHALL NOT abort the access already latched; that access completes and its done pulse is still emitted.
REQ-029 A req asserted while another access is in progress SHALL wait; requests SHALL never be lost while held.

Reset
REQ-030 On rst_n low, at any time including mid-access: state SHALL return to IDLE; all done_o, csr_ack_o SHALL be 0; addr, wdata and rdata outputs SHALL be 0; last-grant SHALL be set to requester 1, so requester 0 wins first; lock SHALL be cleared; no csr write SHALL be issued after reset.

Configuration
REQ-031 With CSR_ARB_RR_EN defined, SHALL round-robin: on a tie, the requester not granted last wins. Without it, SHALL use fixed priority: requester 0 always wins a tie. Lock (REQ-026) SHALL apply in both builds.

Structure
REQ-032 SHALL place the state encoding constants and the DATA_WIDTH/ADDR_WIDTH defaults in the shared csr package, also used by csr_spi and csr.
REQ-033 SHALL have one sub-module, csr_arb_pick: a combinational winner select from req0, req1, last-grant and lock.

Verification
REQ-034 Case: req0 writes addr 0x010 data 0x5A, req1 idle. Check: csr_ack_o is high for exactly one cycle in cycle 2 with addr 0x010 and data 0x5A; req0_done_o pulses in cycle 2.
REQ-035 Case: req1 reads addr 0x100 with csr_rdata_i = 0x3C. Check: req1_done_o pulses in cycle 3 with req1_rdata_o = 0x3C; csr_ack_o stays low.
REQ-036 Case: req0 and req1 both held high with writes. RR build: grants alternate 0,1,0,1. Fixed build: requester 0 gets four consecutive grants before requester 1.
REQ-037 Case: req0_lock_i is high while both requesters request. Check: requester 0 is re-granted 3 times; after lock drops, requester 1 is granted next.
REQ-038 Case: rst_n is asserted in ISSUE of a write. Check: no csr_ack_o pulse; all outputs are 0; the first grant after reset goes to requester 0.
REQ-039 Case: req0 drops req in READ. Check: req0_done_o still pulses with the correct rdata, and no further access is issued for requester 0.

Source files
------------

// File: rtl/csr_arb_pkg.sv
// Shared CSR types: address/data width defaults and arbiter state encoding.
package csr_arb_pkg;
   localparam int CSR_ADDR_WIDTH = 12;
   localparam int CSR_DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_READ  = 2'd2
   } arb_state_t;

   typedef enum logic {
      GNT_REQ0 = 1'b0,
      GNT_REQ1 = 1'b1
   } gnt_t;
endpackage

// File: rtl/csr_arb_if.sv
// Requester and csr-block signals of the CSR arbiter; slave is the arbiter's view.
interface csr_arb_if
   import csr_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = CSR_ADDR_WIDTH,
   parameter int DATA_WIDTH = CSR_DATA_WIDTH
);
   logic                  req0_i;
   logic                  req0_we_i;
   logic                  req0_lock_i;
   logic [ADDR_WIDTH-1:0] req0_addr_i;
   logic [DATA_WIDTH-1:0] req0_wdata_i;
   logic                  req0_done_o;
   logic [DATA_WIDTH-1:0] req0_rdata_o;

   logic                  req1_i;
   logic                  req1_we_i;
   logic                  req1_lock_i;
   logic [ADDR_WIDTH-1:0] req1_addr_i;
   logic [DATA_WIDTH-1:0] req1_wdata_i;
   logic                  req1_done_o;
   logic [DATA_WIDTH-1:0] req1_rdata_o;

   logic [ADDR_WIDTH-1:0] csr_addr_o;
   logic                  csr_ack_o;
   logic [DATA_WIDTH-1:0] csr_wdata_o;
   logic [DATA_WIDTH-1:0] csr_rdata_i;

   modport slave (
      input  req0_i, req0_we_i, req0_lock_i, req0_addr_i, req0_wdata_i,
      output req0_done_o, req0_rdata_o,
      input  req1_i, req1_we_i, req1_lock_i, req1_addr_i, req1_wdata_i,
      output req1_done_o, req1_rdata_o,
      output csr_addr_o, csr_ack_o, csr_wdata_o,
      input  csr_rdata_i
   );

   modport master (
      output req0_i, req0_we_i, req0_lock_i, req0_addr_i, req0_wdata_i,
      input  req0_done_o, req0_rdata_o,
      output req1_i, req1_we_i, req1_lock_i, req1_addr_i, req1_wdata_i,
      input  req1_done_o, req1_rdata_o,
      input  csr_addr_o, csr_ack_o, csr_wdata_o,
      output csr_rdata_i
   );
endinterface

// File: rtl/csr_arb_pick.sv
// Combinational winner select: lock keeps the last owner, else fixed priority to req0,
// or round-robin on a tie when CSR_ARB_RR_EN is defined.
module csr_arb_pick (
   input  logic req0,
   input  logic req1,
   input  logic last_gnt,
   input  logic lock,
   output logic gnt_vld,
   output logic gnt
);
   always_comb begin
      gnt_vld = req0 | req1;
      gnt     = 1'b0;
      if (lock && (last_gnt ? req1 : req0)) begin
         gnt = last_gnt;
      end else if (req0 && req1) begin
`ifdef CSR_ARB_RR_EN
         gnt = ~last_gnt;
`else
         gnt = 1'b0;
`endif
      end else begin
         gnt = req1;
      end
   end
endmodule

// File: rtl/csr_arb.sv
// Two-requester CSR arbiter: write done 2 cycles and read done 3 cycles after the granting IDLE cycle.
// No backpressure; a held request waits in IDLE until granted. Build option CSR_ARB_RR_EN.
module csr_arb
   import csr_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = CSR_ADDR_WIDTH,
   parameter int DATA_WIDTH = CSR_DATA_WIDTH
) (
   input logic      clk,
   input logic      rst_n,
   csr_arb_if.slave bus
);
   arb_state_t            state_q, state_d;
   logic                  owner_q, we_q, lock_q;
   logic                  ack_q, done0_q, done1_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q, rdata0_q, rdata1_q;
   logic                  gnt_vld, gnt, done_pend;
   logic                  grant_en, ack_d, done_d, rd_cap;

   // The done cycle is not a grant slot: the owner still holds req and its lock is sampled here.
   assign done_pend = done0_q | done1_q;

   csr_arb_pick u_pick (
      .req0     (bus.req0_i),
      .req1     (bus.req1_i),
      .last_gnt (owner_q),
      .lock     (lock_q),
      .gnt_vld  (gnt_vld),
      .gnt      (gnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (gnt_vld && !done_pend) state_d = ST_ISSUE;
         ST_ISSUE: state_d = we_q ? ST_IDLE : ST_READ;
         ST_READ:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      grant_en = (state_q == ST_IDLE) && gnt_vld && !done_pend;
      ack_d    = (state_q == ST_ISSUE) && we_q;
      done_d   = ((state_q == ST_ISSUE) && we_q) || (state_q == ST_READ);
      rd_cap   = (state_q == ST_READ);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q  <= GNT_REQ1;
         we_q     <= 1'b0;
         lock_q   <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         ack_q    <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         if (grant_en) begin
            owner_q <= gnt;
            we_q    <= gnt ? bus.req1_we_i    : bus.req0_we_i;
            addr_q  <= gnt ? bus.req1_addr_i  : bus.req0_addr_i;
            wdata_q <= gnt ? bus.req1_wdata_i : bus.req0_wdata_i;
         end
         ack_q   <= ack_d;
         done0_q <= done_d & ~owner_q;
         done1_q <= done_d & owner_q;
         if (rd_cap && !owner_q) rdata0_q <= bus.csr_rdata_i;
         if (rd_cap && owner_q)  rdata1_q <= bus.csr_rdata_i;
         lock_q  <= (done0_q & bus.req0_lock_i) | (done1_q & bus.req1_lock_i);
      end
   end

   assign bus.csr_addr_o   = addr_q;
   assign bus.csr_wdata_o  = wdata_q;
   assign bus.csr_ack_o    = ack_q;
   assign bus.req0_done_o  = done0_q;
   assign bus.req1_done_o  = done1_q;
   assign bus.req0_rdata_o = rdata0_q;
   assign bus.req1_rdata_o = rdata1_q;
endmodule

// File: tb/tb_csr_arb.sv
// Bench for csr_arb: requester agents, a csr read model and an in-order completion scoreboard.
`timescale 1ns/1ps
module tb_csr_arb;
   import csr_arb_pkg::*;
   localparam int AW = CSR_ADDR_WIDTH;
   localparam int DW = CSR_DATA_WIDTH;

   typedef struct {
      int            who;
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   int   mon_who;
   logic [DW-1:0] mon_rd;

   csr_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   csr_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // csr block model: registered read, data is a fixed function of the address
   function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
      return a[7:0] ^ 8'h3C;
   endfunction

   always @(posedge clk) bus.csr_rdata_i <= rd_fn(bus.csr_addr_o);

   function automatic void push_exp(input int who, input bit we, input logic [AW-1:0] a,
                                    input logic [DW-1:0] d);
      exp_t e;
      e.who = who; e.we = we; e.addr = a; e.data = d;
      exp_q.push_back(e);
   endfunction

   // Scoreboard: every done pulse must match the next expected completion in order
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.req0_done_o && bus.req1_done_o) begin
            checks++; failures++;
            $display("FAIL done_overlap: both done pulses high, required at most one");
         end else if (bus.req0_done_o || bus.req1_done_o) begin
            mon_who = bus.req1_done_o ? 1 : 0;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected: done from req%0d, required no completion", mon_who);
            end else begin
               mon_e = exp_q.pop_front();
               if (mon_who !== mon_e.who) begin
                  failures++;
                  $display("FAIL sb_grant_order: done from req%0d, required req%0d", mon_who, mon_e.who);
               end
               checks++;
               if (bus.csr_addr_o !== mon_e.addr) begin
                  failures++;
                  $display("FAIL sb_addr: got %h required %h", bus.csr_addr_o, mon_e.addr);
               end
               if (mon_e.we) begin
                  checks++;
                  if (bus.csr_ack_o !== 1'b1) begin
                     failures++;
                     $display("FAIL sb_write_ack: got %b required 1", bus.csr_ack_o);
                  end
                  checks++;
                  if (bus.csr_wdata_o !== mon_e.data) begin
                     failures++;
                     $display("FAIL sb_wdata: got %h required %h", bus.csr_wdata_o, mon_e.data);
                  end
               end else begin
                  mon_rd = (mon_who == 1) ? bus.req1_rdata_o : bus.req0_rdata_o;
                  checks++;
                  if (bus.csr_ack_o !== 1'b0) begin
                     failures++;
                     $display("FAIL sb_read_ack: got %b required 0", bus.csr_ack_o);
                  end
                  checks++;
                  if (mon_rd !== mon_e.data) begin
                     failures++;
                     $display("FAIL sb_rdata: req%0d got %h required %h", mon_who, mon_rd, mon_e.data);
                  end
               end
            end
         end else begin
            checks++;
            if (bus.csr_ack_o !== 1'b0) begin
               failures++;
               $display("FAIL stray_ack: ack %b without write completion, required 0", bus.csr_ack_o);
            end
         end
      end
   end

   task automatic set_req(input int who, input bit req, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit lk);
      if (who == 0) begin
         bus.req0_i = req; bus.req0_we_i = we; bus.req0_addr_i = a;
         bus.req0_wdata_i = d; bus.req0_lock_i = lk;
      end else begin
         bus.req1_i = req; bus.req1_we_i = we; bus.req1_addr_i = a;
         bus.req1_wdata_i = d; bus.req1_lock_i = lk;
      end
   endtask

   task automatic wait_done(input int who, output int cyc);
      bit got = 1'b0;
      cyc = 0;
      while (!got && cyc <= 60) begin
         @(negedge clk);
         if (((who == 0) ? bus.req0_done_o : bus.req1_done_o) === 1'b1) got = 1'b1;
         else cyc++;
      end
      if (!got) begin
         checks++; failures++;
         $display("FAIL timeout_req%0d: no done within 60 cycles, required a done pulse", who);
         cyc = -1;
      end
   endtask

   // Issues n back-to-back accesses, holding req until each done; first lock_n are locked
   task automatic agent(input int who, input int n, input bit we, input logic [AW-1:0] base,
                        input logic [DW-1:0] dbase, input int lock_n);
      int cyc;
      for (int k = 0; k < n; k++) begin
         set_req(who, 1'b1, we, base + AW'(k), dbase + DW'(k), k < lock_n);
         wait_done(who, cyc);
         @(posedge clk); #1;
      end
      set_req(who, 1'b0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      set_req(0, 1'b0, 1'b0, '0, '0, 1'b0);
      set_req(1, 1'b0, 1'b0, '0, '0, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      set_req(0, 1'b0, 1'b0, '0, '0, 1'b0);
      set_req(1, 1'b0, 1'b0, '0, '0, 1'b0);
      #3;
      checks++;
      if ({bus.csr_ack_o, bus.req0_done_o, bus.req1_done_o} !== 3'b000) begin
         failures++;
         $display("FAIL reset_strobes: ack/done0/done1=%b required 000",
                  {bus.csr_ack_o, bus.req0_done_o, bus.req1_done_o});
      end
      checks++;
      if ({bus.csr_addr_o, bus.csr_wdata_o, bus.req0_rdata_o, bus.req1_rdata_o} !== '0) begin
         failures++;
         $display("FAIL reset_data: addr=%h wdata=%h rdata0=%h rdata1=%h required all 0",
                  bus.csr_addr_o, bus.csr_wdata_o, bus.req0_rdata_o, bus.req1_rdata_o);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_write();
      int ack_cnt = 0, ack_cyc = -1, done_cyc = -1;
      push_exp(0, 1'b1, 12'h010, 8'h5A);
      set_req(0, 1'b1, 1'b1, 12'h010, 8'h5A, 1'b0);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.csr_ack_o === 1'b1) begin ack_cnt++; ack_cyc = c; end
         if (bus.req0_done_o === 1'b1) done_cyc = c;
         @(posedge clk); #1;
         if (c == 2) set_req(0, 1'b0, 1'b0, '0, '0, 1'b0);
      end
      checks++;
      if (ack_cnt !== 1) begin
         failures++; $display("FAIL write_ack_count: got %0d required 1", ack_cnt);
      end
      checks++;
      if (ack_cyc !== 2) begin
         failures++; $display("FAIL write_ack_cycle: got %0d required 2", ack_cyc);
      end
      checks++;
      if (done_cyc !== 2) begin
         failures++; $display("FAIL write_done_cycle: got %0d required 2", done_cyc);
      end
   endtask

   task automatic test_read();
      int ack_cnt = 0, done_cyc = -1;
      push_exp(1, 1'b0, 12'h100, 8'h3C);
      set_req(1, 1'b1, 1'b0, 12'h100, 8'h00, 1'b0);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.csr_ack_o === 1'b1) ack_cnt++;
         if (bus.req1_done_o === 1'b1) done_cyc = c;
         @(posedge clk); #1;
         if (c == 3) set_req(1, 1'b0, 1'b0, '0, '0, 1'b0);
      end
      checks++;
      if (done_cyc !== 3) begin
         failures++; $display("FAIL read_done_cycle: got %0d required 3", done_cyc);
      end
      checks++;
      if (ack_cnt !== 0) begin
         failures++; $display("FAIL read_ack_count: got %0d required 0", ack_cnt);
      end
      // other traffic must not disturb req1's last read data
      push_exp(0, 1'b0, 12'h0A5, 8'h99);
      agent(0, 1, 1'b0, 12'h0A5, 8'h00, 0);
      push_exp(1, 1'b1, 12'h020, 8'h11);
      agent(1, 1, 1'b1, 12'h020, 8'h11, 0);
      checks++;
      if (bus.req1_rdata_o !== 8'h3C) begin
         failures++; $display("FAIL rdata_hold: got %h required 3c", bus.req1_rdata_o);
      end
   endtask

   task automatic test_arb_tie();
      do_reset();
      for (int k = 0; k < 4; k++) begin
`ifdef CSR_ARB_RR_EN
         push_exp(0, 1'b1, 12'h200 + AW'(k), 8'h80 + DW'(k));
         push_exp(1, 1'b1, 12'h300 + AW'(k), 8'hC0 + DW'(k));
`else
         push_exp(0, 1'b1, 12'h200 + AW'(k), 8'h80 + DW'(k));
`endif
      end
`ifndef CSR_ARB_RR_EN
      for (int k = 0; k < 4; k++) push_exp(1, 1'b1, 12'h300 + AW'(k), 8'hC0 + DW'(k));
`endif
      fork
         agent(0, 4, 1'b1, 12'h200, 8'h80, 0);
         agent(1, 4, 1'b1, 12'h300, 8'hC0, 0);
      join
      checks++;
      if (exp_q.size() !== 0) begin
         failures++; $display("FAIL tie_pending: %0d completions outstanding, required 0", exp_q.size());
      end
   endtask

   task automatic test_lock();
      do_reset();
      for (int k = 0; k < 4; k++) push_exp(0, 1'b1, 12'h040 + AW'(k), 8'h10 + DW'(k));
      push_exp(1, 1'b1, 12'h050, 8'h20);
      fork
         agent(0, 4, 1'b1, 12'h040, 8'h10, 3);
         agent(1, 1, 1'b1, 12'h050, 8'h20, 0);
      join
      // requester 1 holds a lock against the default winner
      for (int k = 0; k < 3; k++) push_exp(1, 1'b1, 12'h060 + AW'(k), 8'h30 + DW'(k));
      push_exp(0, 1'b1, 12'h070, 8'h40);
      fork
         agent(1, 3, 1'b1, 12'h060, 8'h30, 2);
         begin
            @(posedge clk); #1;
            agent(0, 1, 1'b1, 12'h070, 8'h40, 0);
         end
      join
      checks++;
      if (exp_q.size() !== 0) begin
         failures++; $display("FAIL lock_pending: %0d completions outstanding, required 0", exp_q.size());
      end
   endtask

   task automatic test_req_drop();
      int done_cnt = 0, done_cyc = -1, ack_cnt = 0;
      push_exp(0, 1'b0, 12'h0F0, 8'hCC);
      set_req(0, 1'b1, 1'b0, 12'h0F0, 8'h00, 1'b0);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.req0_done_o === 1'b1) begin done_cnt++; done_cyc = c; end
         if (bus.csr_ack_o === 1'b1) ack_cnt++;
         @(posedge clk); #1;
         if (c == 1) set_req(0, 1'b0, 1'b0, '0, '0, 1'b0);
      end
      checks++;
      if (done_cyc !== 3) begin
         failures++; $display("FAIL drop_done_cycle: got %0d required 3", done_cyc);
      end
      checks++;
      if (done_cnt !== 1) begin
         failures++; $display("FAIL drop_done_count: got %0d required 1", done_cnt);
      end
      checks++;
      if (ack_cnt !== 0) begin
         failures++; $display("FAIL drop_ack_count: got %0d required 0", ack_cnt);
      end
   endtask

   task automatic test_reset_mid();
      set_req(0, 1'b1, 1'b1, 12'h0AA, 8'h77, 1'b0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      set_req(0, 1'b0, 1'b0, '0, '0, 1'b0);
      #1;
      checks++;
      if ({bus.csr_ack_o, bus.req0_done_o, bus.req1_done_o} !== 3'b000) begin
         failures++;
         $display("FAIL midrst_strobes: ack/done0/done1=%b required 000",
                  {bus.csr_ack_o, bus.req0_done_o, bus.req1_done_o});
      end
      checks++;
      if ({bus.csr_addr_o, bus.csr_wdata_o, bus.req0_rdata_o, bus.req1_rdata_o} !== '0) begin
         failures++;
         $display("FAIL midrst_data: addr=%h wdata=%h rdata0=%h rdata1=%h required all 0",
                  bus.csr_addr_o, bus.csr_wdata_o, bus.req0_rdata_o, bus.req1_rdata_o);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (bus.csr_ack_o !== 1'b0) begin
            failures++; $display("FAIL midrst_ack: got %b required 0", bus.csr_ack_o);
         end
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      push_exp(0, 1'b1, 12'h0B0, 8'h66);
      push_exp(1, 1'b1, 12'h0C0, 8'h55);
      fork
         agent(0, 1, 1'b1, 12'h0B0, 8'h66, 0);
         agent(1, 1, 1'b1, 12'h0C0, 8'h55, 0);
      join
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_arb_tie();
      test_lock();
      test_req_drop();
      test_reset_mid();
      repeat (4) @(posedge clk);
      checks++;
      if (exp_q.size() !== 0) begin
         failures++; $display("FAIL final_pending: %0d completions outstanding, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end
endmodule
